lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, the maximum cycles to hold a read while halt stays high.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have core-side inputs:
- req_valid, 1 bit.
- req_we, 1 bit.
- req_size, 2 bits: 0 byte, 1 half, 2 word, 3 illegal.
- req_unsigned, 1 bit.
- req_addr, 32 bits.
- req_wdata, 32 bits.
REQ-005 SHALL have core-side outputs:
- req_ready, 1 bit.
- rsp_valid, 1 bit.
- rsp_rdata, 32 bits.
- rsp_err, 1 bit.
REQ-006 SHALL have memory-side outputs, all registered: data_addr 32, data_in 32, write 1, read 1, byte_en 4.
REQ-007 SHALL have memory-side inputs: data_out 32, halt 1.

Function
REQ-008 SHALL implement FSM states IDLE, WRITE, READ, RESP; req_ready SHALL be 1 only in IDLE.
REQ-009 SHALL accept a request in IDLE when req_valid=1; req_valid outside IDLE is ignored (no queuing).
REQ-010 SHALL flag misalignment when:
- size 3, or
- half with addr[0]=1, or
- word with addr[1:0]!=0.
A misaligned request causes no memory access, goes IDLE->RESP, and gives rsp_valid=1, rsp_err=1, rsp_rdata=0 one cycle after acceptance.
REQ-011 SHALL generate byte_en as:
- byte: 4'b0001<<addr[1:0]
- half: 4'b0011<<addr[1:0]
- word: 4'b1111
REQ-012 SHALL drive data_in as the byte replicated x4, the half replicated x2, or the word unchanged.
REQ-013 SHALL drive data_addr to the full req_addr (no masking); the memory decodes the address.
REQ-014 SHALL handle a store as: accept at T, write=1 at T+1 for exactly one cycle (state WRITE), then rsp_valid=1, rsp_err=0, rsp_rdata=0 at T+2.
REQ-015 SHALL handle a load as: accept at T, read=1 from T+1 (state READ), with read, data_addr and byte_en held stable until halt is sampled 0.
REQ-016 SHALL, on the edge where read=1 and halt=0, capture data_out, drop read, and enter RESP; with the expected memory (halt high for exactly one cycle) rsp_valid asserts at T+3.
REQ-017 SHALL align load data by shifting data_out right by 8*addr[1:0], then zero-extend when req_unsigned=1, otherwise sign-extend from bit 7 (byte) or bit 15 (half); a word is passed unchanged.
REQ-018 SHALL count cycles in READ with halt=1 using a 4-bit counter cleared on entry; when the count reaches TIMEOUT_CYCLES it drops read, enters RESP, and responds with rsp_err=1, rsp_rdata=0.
REQ-019 SHALL hold rsp_valid for exactly one cycle (the RESP state), after which the FSM returns to IDLE; the core cannot back-pressure the response.
REQ-020 SHALL drive write and read to 0 whenever neither is active, and SHALL never assert both in the same cycle.

Reset
REQ-021 SHALL, while reset=0, force immediately (asynchronously):
- state IDLE, counter 0;
- read=0, write=0, byte_en=0, data_addr=0, data_in=0;
- rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-022 SHALL, on reset asserted mid-load or mid-store, abandon the access with no response, and give req_ready=1 on the first cycle after release.

Structure
REQ-023 SHALL place in shared package lsu_pkg:
- the state enum;
- the size encoding (SZ_BYTE, SZ_HALF, SZ_WORD);
- the default TIMEOUT_CYCLES.
REQ-024 SHALL instantiate one combinational sub-module, lsu_align, which performs byte-enable generation, store-data replication and load extraction/extension; lsu keeps the FSM and registers.

Verification
REQ-025 Word store addr=0x100, wdata=0xDEADBEEF -> at T+1: write=1, byte_en=4'hF, data_in=0xDEADBEEF; at T+2: rsp_valid=1, rsp_err=0.
REQ-026 Byte store addr=0x103, wdata=0x000000A5 -> byte_en=4'b1000, data_in=0xA5A5A5A5.
REQ-027 Signed byte load addr=0x102 with data_out=0x12F03456 -> rsp_rdata=0xFFFFFFF0 at T+3; the same access with req_unsigned=1 -> 0x000000F0.
REQ-028 Half load addr=0x101 -> no read asserted, rsp_valid=1 and rsp_err=1 at T+1.
REQ-029 Load with halt held at 1 -> read drops after 15 cycles, then rsp_err=1 and rsp_rdata=0.
REQ-030 reset=0 pulsed during READ -> read=0 immediately, no rsp_valid, req_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the load/store unit: FSM state
//               encoding, access-size encoding, default read timeout and an
//               alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int TIMEOUT_CYCLES_DEFAULT = 15;

    // An access is unusable if the size code is illegal or the address is not
    // a multiple of the access width.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = offset[0];
            SZ_WORD: mis = (offset != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane steering for the LSU.
//               Ports:
//                 size_i, unsigned_i, offset_i : access descriptor
//                 wdata_i      : raw store data from the core
//                 rdata_raw_i  : raw word returned by memory
//                 byte_en_o    : byte lane enables
//                 wdata_o      : store data replicated across lanes
//                 rdata_o      : load data shifted down and extended
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_raw_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] w_shifted;

    assign w_shifted = rdata_raw_i >> {offset_i, 3'b000};

    always_comb begin
        byte_en_o = 4'b0000;
        wdata_o   = wdata_i;
        rdata_o   = rdata_raw_i;
        case (size_i)
            SZ_BYTE: begin
                byte_en_o = 4'b0001 << offset_i;
                wdata_o   = {4{wdata_i[7:0]}};
                rdata_o   = unsigned_i ? {24'h000000, w_shifted[7:0]}
                                       : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            SZ_HALF: begin
                byte_en_o = 4'b0011 << offset_i;
                wdata_o   = {2{wdata_i[15:0]}};
                rdata_o   = unsigned_i ? {16'h0000, w_shifted[15:0]}
                                       : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            SZ_WORD: begin
                byte_en_o = 4'b1111;
                wdata_o   = wdata_i;
                rdata_o   = rdata_raw_i;
            end
            default: begin
                byte_en_o = 4'b0000;
                wdata_o   = wdata_i;
                rdata_o   = 32'h0000_0000;
            end
        endcase
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Single-outstanding load/store unit between a core and a
//               halting memory port.
//               Core side   : req_valid/req_we/req_size/req_unsigned/req_addr/
//                             req_wdata in, req_ready/rsp_valid/rsp_rdata/
//                             rsp_err out.
//               Memory side : data_addr/data_in/write/read/byte_en out (all
//                             registered), data_out/halt in.
//               clk rising edge, reset asynchronous active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    // core side
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    // memory side
    output logic [31:0] data_addr,
    output logic [31:0] data_in,
    output logic        write,
    output logic        read,
    output logic [3:0]  byte_en,
    input  logic [31:0] data_out,
    input  logic        halt
);

    // Last count value before the timeout fires: read stays up for exactly
    // TIMEOUT_CYCLES halted cycles.
    localparam logic [3:0] c_cnt_last = 4'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [31:0] data_in_q, data_in_d;
    logic [3:0]  byte_en_q, byte_en_d;
    logic        write_q, write_d;
    logic        read_q, read_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [1:0]  w_sel_size;
    logic        w_sel_uns;
    logic [1:0]  w_sel_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic        w_mis;

    // The aligner serves the incoming request while idle and the latched
    // access (held in the memory-side registers) while a load is in flight.
    assign w_sel_size = (state_q == ST_IDLE) ? req_size     : size_q;
    assign w_sel_uns  = (state_q == ST_IDLE) ? req_unsigned : uns_q;
    assign w_sel_off  = (state_q == ST_IDLE) ? req_addr[1:0] : data_addr_q[1:0];
    assign w_mis      = is_misaligned(req_size, req_addr[1:0]);

    lsu_align u_align (
        .size_i      (w_sel_size),
        .unsigned_i  (w_sel_uns),
        .offset_i    (w_sel_off),
        .wdata_i     (req_wdata),
        .rdata_raw_i (data_out),
        .byte_en_o   (w_be),
        .wdata_o     (w_wdata),
        .rdata_o     (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            data_addr_q <= 32'h0000_0000;
            data_in_q   <= 32'h0000_0000;
            byte_en_q   <= 4'b0000;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            data_addr_q <= data_addr_d;
            data_in_q   <= data_in_d;
            byte_en_q   <= byte_en_d;
            write_q     <= write_d;
            read_q      <= read_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        uns_d       = uns_q;
        data_addr_d = data_addr_q;
        data_in_d   = data_in_q;
        byte_en_d   = byte_en_q;
        write_d     = 1'b0;
        read_d      = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    cnt_d       = 4'd0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 32'h0000_0000;
                    if (w_mis) begin
                        // Rejected without touching memory.
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        data_addr_d = req_addr;
                        data_in_d   = w_wdata;
                        byte_en_d   = w_be;
                        if (req_we) begin
                            write_d = 1'b1;
                            state_d = ST_WRITE;
                        end else begin
                            read_d  = 1'b1;
                            state_d = ST_READ;
                        end
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_READ: begin
                if (!halt) begin
                    rsp_rdata_d = w_rdata;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (cnt_q == c_cnt_last) begin
                    rsp_rdata_d = 32'h0000_0000;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    read_d = 1'b1;
                    cnt_d  = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign data_addr = data_addr_q;
    assign data_in   = data_in_q;
    assign write     = write_q;
    assign read      = read_q;
    assign byte_en   = byte_en_q;

endmodule : lsu
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Directed, table-driven bench for the load/store unit with a
//               one-cycle-halt memory, plus timeout and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic        write;
    logic        read;
    logic [3:0]  byte_en;
    logic [31:0] data_out;
    logic        halt;

    int checks = 0;
    int errors = 0;

    lsu #(.TIMEOUT_CYCLES(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .data_addr    (data_addr),
        .data_in      (data_in),
        .write        (write),
        .read         (read),
        .byte_en      (byte_en),
        .data_out     (data_out),
        .halt         (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] dout;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] din;
        logic [31:0] rdata;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        drive_req(v.we, v.size, v.uns, v.addr, v.wdata);
        @(negedge clk);                         // T+1
        req_valid = 1'b0;
        if (v.mis) begin
            chk({tag, ".mis_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({tag, ".mis_err"},   {31'd0, rsp_err},   32'd1);
            chk({tag, ".mis_rdata"}, rsp_rdata,          32'd0);
            chk({tag, ".mis_rw"},    {30'd0, read, write}, 32'd0);
        end else if (v.we) begin
            chk({tag, ".st_write"}, {30'd0, read, write}, 32'd1);
            chk({tag, ".st_be"},    {28'd0, byte_en},     {28'd0, v.be});
            chk({tag, ".st_din"},   data_in,              v.din);
            chk({tag, ".st_addr"},  data_addr,            v.addr);
            chk({tag, ".st_ready"}, {31'd0, req_ready},   32'd0);
            @(negedge clk);                     // T+2
            chk({tag, ".st_rsp"},   {30'd0, rsp_valid, rsp_err}, 32'd2);
            chk({tag, ".st_rdata"}, rsp_rdata,            32'd0);
            chk({tag, ".st_wdrop"}, {31'd0, write},       32'd0);
        end else begin
            chk({tag, ".ld_read"}, {30'd0, read, write}, 32'd2);
            chk({tag, ".ld_be"},   {28'd0, byte_en},     {28'd0, v.be});
            chk({tag, ".ld_addr"}, data_addr,            v.addr);
            halt     = 1'b1;
            data_out = 32'hBAD0_BAD0;
            @(negedge clk);                     // T+2
            chk({tag, ".ld_hold"}, {31'd0, read},        32'd1);
            chk({tag, ".ld_addr2"}, data_addr,           v.addr);
            chk({tag, ".ld_norsp"}, {31'd0, rsp_valid},  32'd0);
            halt     = 1'b0;
            data_out = v.dout;
            @(negedge clk);                     // T+3
            chk({tag, ".ld_rsp"},   {30'd0, rsp_valid, rsp_err}, 32'd2);
            chk({tag, ".ld_rdata"}, rsp_rdata,           v.rdata);
            chk({tag, ".ld_rdrop"}, {31'd0, read},       32'd0);
        end
        @(negedge clk);
        chk({tag, ".one_cycle"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        int n;
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        data_out     = 32'd0;
        halt         = 1'b0;

        //          we    sz    uns   addr          wdata          dout           mis   be       din            rdata
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00A5, 32'h0,         1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0};
        vecs[2]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_BEEF, 32'h0,         1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0102, 32'h0,         32'h12F0_3456, 1'b0, 4'b0100, 32'h0,         32'hFFFF_FFF0};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0102, 32'h0,         32'h12F0_3456, 1'b0, 4'b0100, 32'h0,         32'h0000_00F0};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0100, 32'h0,         32'h12F0_8456, 1'b0, 4'b0011, 32'h0,         32'hFFFF_8456};
        vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0,         32'h8001_0000, 1'b0, 4'b1100, 32'h0,         32'h0000_8001};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0,         32'hCAFE_F00D, 1'b0, 4'b1111, 32'h0,         32'hCAFE_F00D};
        vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0101, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0102, 32'h1111_1111, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[11] = '{1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0,         32'h0000_7F00, 1'b0, 4'b0010, 32'h0,         32'h0000_007F};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.outs", {28'd0, read, write, rsp_valid, rsp_err}, 32'd0);
        chk("rst.be",   {28'd0, byte_en}, 32'd0);
        chk("rst.addr", data_addr, 32'd0);
        chk("rst.din",  data_in,   32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst.ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // Timeout: halt held high for the whole load.
        @(negedge clk);
        drive_req(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        halt      = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!read) break;
            n++;
            @(negedge clk);
        end
        chk("to.read_cycles", n, 32'd15);
        chk("to.rsp",   {30'd0, rsp_valid, rsp_err}, 32'd3);
        chk("to.rdata", rsp_rdata, 32'd0);
        halt = 1'b0;
        @(negedge clk);
        chk("to.idle", {30'd0, rsp_valid, req_ready}, 32'd1);

        // Reset mid-load.
        @(negedge clk);
        drive_req(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        halt      = 1'b1;
        chk("rl.read_before", {31'd0, read}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rl.read_async", {31'd0, read}, 32'd0);
        chk("rl.addr_async", data_addr, 32'd0);
        chk("rl.be_async",   {28'd0, byte_en}, 32'd0);
        chk("rl.rsp_async",  {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        halt  = 1'b0;
        @(negedge clk);
        chk("rl.ready_after", {30'd0, rsp_valid, req_ready}, 32'd1);
        @(negedge clk);
        chk("rl.no_rsp", {29'd0, rsp_valid, read, req_ready}, 32'd1);

        // Reset mid-store.
        drive_req(1'b1, 2'd2, 1'b0, 32'h0000_0400, 32'h5555_AAAA);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rs.write_before", {31'd0, write}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rs.write_async", {31'd0, write}, 32'd0);
        chk("rs.din_async",   data_in, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rs.ready_after", {30'd0, rsp_valid, req_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_lsu
`default_nettype wire
